// File: rtl/pwm_capture.sv
// Receive side of the differential PWM DAC link: locks to the frame boundary and
// rebuilds the signed sample from the high-cycle counts of pwm_pos/pwm_neg each frame.
module pwm_capture #(
  parameter int WIDTH = 8,
  parameter int SYNC  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwm_pos,
  input  logic             pwm_neg,
  input  logic             clear_err,
  output logic             sample_valid,
  output logic [WIDTH-1:0] pos_level,
  output logic [WIDTH-1:0] neg_level,
  output logic [WIDTH:0]   sample,
  output logic             locked,
  output logic             frame_err,
  output logic             overlap_err,
  output logic             fsm_state
);

  typedef enum logic {HUNT = 1'b0, LOCK = 1'b1} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_q, state_d;
  logic [SYNC-1:0]  pos_sync_q, neg_sync_q;
  logic             pos_prev_q, neg_prev_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_p_q, acc_p_d, acc_n_q, acc_n_d;
  logic [WIDTH-1:0] pos_lvl_q, pos_lvl_d, neg_lvl_q, neg_lvl_d;
  logic [WIDTH:0]   sample_q, sample_d;
  logic             valid_q, valid_d, ferr_q, ferr_d, ovl_q, ovl_d;
  logic             pos_s, neg_s, rise;

  // Counts one more high cycle but never wraps past all-ones.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] a, input logic b);
    return (b && (a != CNT_MAX)) ? a + ONE : a;
  endfunction

  assign pos_s = pos_sync_q[SYNC-1];
  assign neg_s = neg_sync_q[SYNC-1];
  assign rise  = (pos_s & ~pos_prev_q) | (neg_s & ~neg_prev_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_p_d   = acc_p_q;
    acc_n_d   = acc_n_q;
    pos_lvl_d = pos_lvl_q;
    neg_lvl_d = neg_lvl_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    // A fresh overlap outranks a simultaneous clear.
    ovl_d     = (pos_s & neg_s) ? 1'b1 : (clear_err ? 1'b0 : ovl_q);
    case (state_q)
      HUNT: begin
        if (rise) begin
          state_d = LOCK;
          cnt_d   = ONE;
          acc_p_d = {{(WIDTH-1){1'b0}}, pos_s};
          acc_n_d = {{(WIDTH-1){1'b0}}, neg_s};
        end
      end
      LOCK: begin
        if (rise && (cnt_q != '0)) begin
          // Edge off the boundary: drop this frame and realign on the new edge.
          ferr_d  = 1'b1;
          cnt_d   = ONE;
          acc_p_d = {{(WIDTH-1){1'b0}}, pos_s};
          acc_n_d = {{(WIDTH-1){1'b0}}, neg_s};
        end else begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == '0) begin
            acc_p_d = {{(WIDTH-1){1'b0}}, pos_s};
            acc_n_d = {{(WIDTH-1){1'b0}}, neg_s};
          end else begin
            acc_p_d = sat_inc(acc_p_q, pos_s);
            acc_n_d = sat_inc(acc_n_q, neg_s);
          end
          if (cnt_q == CNT_MAX) begin
            valid_d   = 1'b1;
            pos_lvl_d = sat_inc(acc_p_q, pos_s);
            neg_lvl_d = sat_inc(acc_n_q, neg_s);
            sample_d  = {1'b0, pos_lvl_d} - {1'b0, neg_lvl_d};
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      pos_sync_q <= '0;
      neg_sync_q <= '0;
      pos_prev_q <= 1'b0;
      neg_prev_q <= 1'b0;
      cnt_q      <= '0;
      acc_p_q    <= '0;
      acc_n_q    <= '0;
      pos_lvl_q  <= '0;
      neg_lvl_q  <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovl_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_sync_q <= {pos_sync_q[SYNC-2:0], pwm_pos};
      neg_sync_q <= {neg_sync_q[SYNC-2:0], pwm_neg};
      pos_prev_q <= pos_s;
      neg_prev_q <= neg_s;
      cnt_q      <= cnt_d;
      acc_p_q    <= acc_p_d;
      acc_n_q    <= acc_n_d;
      pos_lvl_q  <= pos_lvl_d;
      neg_lvl_q  <= neg_lvl_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovl_q      <= ovl_d;
    end
  end

  assign sample_valid = valid_q;
  assign pos_level    = pos_lvl_q;
  assign neg_level    = neg_lvl_q;
  assign sample       = sample_q;
  assign locked       = (state_q == LOCK);
  assign frame_err    = ferr_q;
  assign overlap_err  = ovl_q;
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (WIDTH=8, SYNC=2): frames are driven as 256-cycle
// PWM patterns and the strobed levels are compared with hand-computed values.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pwm_pos = 1'b0;
  logic       pwm_neg = 1'b0;
  logic       clear_err = 1'b0;
  logic       sample_valid;
  logic [7:0] pos_level, neg_level;
  logic [8:0] sample;
  logic       locked, frame_err, overlap_err, fsm_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  pwm_capture #(.WIDTH(8), .SYNC(2)) dut (
    .clk(clk), .reset(reset), .pwm_pos(pwm_pos), .pwm_neg(pwm_neg),
    .clear_err(clear_err), .sample_valid(sample_valid), .pos_level(pos_level),
    .neg_level(neg_level), .sample(sample), .locked(locked), .frame_err(frame_err),
    .overlap_err(overlap_err), .fsm_state(fsm_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Strobe monitor sampled on the falling edge
  int         cyc = 0;
  int         strobe_cnt = 0;
  int         ferr_cnt = 0;
  int         last_strobe_cyc = 0;
  int         strobe_gap = 0;
  logic [7:0] cap_pos = '0, cap_neg = '0;
  logic [8:0] cap_sample = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid) begin
      strobe_cnt      = strobe_cnt + 1;
      strobe_gap      = cyc - last_strobe_cyc;
      last_strobe_cyc = cyc;
      cap_pos         = pos_level;
      cap_neg         = neg_level;
      cap_sample      = sample;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
  end

  // Driver: frame cycles s..e-1, pos high for i<p, neg high for i<n
  task automatic drive_cycles(input int p, input int n, input int s, input int e);
    for (int i = s; i < e; i++) begin
      pwm_pos = (i < p);
      pwm_neg = (i < n);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      pwm_pos = i[0];
      pwm_neg = ~i[0];
      @(posedge clk);
      #1;
    end
    vec_cnt++;
    if ({sample_valid, pos_level, neg_level, sample, frame_err, overlap_err} !== 28'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs got %h required 0",
               {sample_valid, pos_level, neg_level, sample, frame_err, overlap_err});
    end
    vec_cnt++;
    if (locked !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_locked got %b required 0", locked);
    end
    pwm_pos = 1'b0;
    pwm_neg = 1'b0;
    reset   = 1'b0;
    drive_cycles(0, 0, 0, 300);
    vec_cnt++;
    if (strobe_cnt !== 0 || ferr_cnt !== 0) begin
      err_cnt++;
      $display("FAIL idle_no_strobe got strobes=%0d ferr=%0d required 0/0", strobe_cnt, ferr_cnt);
    end
    vec_cnt++;
    if (locked !== 1'b0 || fsm_state !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_hunt got locked=%b state=%b required 0/0", locked, fsm_state);
    end
  endtask

  task automatic test_basic_frames();
    int s0, f0;
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    drive_cycles(64, 0, 0, 8);
    vec_cnt++;
    if (locked !== 1'b1 || strobe_cnt !== s0) begin
      err_cnt++;
      $display("FAIL first_lock got locked=%b strobes=%0d required 1/%0d", locked, strobe_cnt - s0, 0);
    end
    drive_cycles(64, 0, 8, 256);
    drive_cycles(64, 0, 0, 8);
    vec_cnt++;
    if (strobe_cnt !== s0 + 1 || cap_pos !== 8'd64 || cap_neg !== 8'd0 || cap_sample !== 9'h040) begin
      err_cnt++;
      $display("FAIL pos64 got n=%0d pos=%0d neg=%0d sample=%h required 1/64/0/040",
               strobe_cnt - s0, cap_pos, cap_neg, cap_sample);
    end
    drive_cycles(64, 0, 8, 256);
    drive_cycles(64, 0, 0, 8);
    vec_cnt++;
    if (strobe_cnt !== s0 + 2 || strobe_gap !== 256) begin
      err_cnt++;
      $display("FAIL strobe_spacing got n=%0d gap=%0d required 2/256", strobe_cnt - s0, strobe_gap);
    end
    vec_cnt++;
    if (ferr_cnt !== f0) begin
      err_cnt++;
      $display("FAIL boundary_rise_no_err got %0d required 0", ferr_cnt - f0);
    end
    drive_cycles(64, 0, 8, 256);
  endtask

  task automatic test_levels();
    int         tp[5] = '{0, 0, 255, 256, 64};
    int         tn[5] = '{200, 0, 0, 0, 0};
    logic [7:0] ep[5] = '{8'd0, 8'd0, 8'd255, 8'd255, 8'd64};
    logic [7:0] en[5] = '{8'd200, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [8:0] es[5] = '{9'h138, 9'h000, 9'h0FF, 9'h0FF, 9'h040};
    int s0;
    for (int k = 0; k < 5; k++) begin
      drive_cycles(tp[k], tn[k], 0, 256);
      s0 = strobe_cnt;
      drive_cycles(tp[k], tn[k], 0, 8);
      vec_cnt++;
      if (strobe_cnt !== s0 + 1 || cap_pos !== ep[k] || cap_neg !== en[k] || cap_sample !== es[k]
          || locked !== 1'b1) begin
        err_cnt++;
        $display("FAIL levels_%0d got n=%0d pos=%0d neg=%0d sample=%h locked=%b required 1/%0d/%0d/%h/1",
                 k, strobe_cnt - s0, cap_pos, cap_neg, cap_sample, locked, ep[k], en[k], es[k]);
      end
      drive_cycles(tp[k], tn[k], 8, 256);
    end
  endtask

  task automatic test_frame_err();
    int s0, f0;
    drive_cycles(64, 0, 0, 8);
    s0 = strobe_cnt;
    f0 = ferr_cnt;
    drive_cycles(64, 0, 8, 100);
    drive_cycles(64, 0, 0, 8);
    vec_cnt++;
    if (ferr_cnt !== f0 + 1) begin
      err_cnt++;
      $display("FAIL frame_err_pulse got %0d cycles required 1", ferr_cnt - f0);
    end
    drive_cycles(64, 0, 8, 256);
    drive_cycles(64, 0, 0, 8);
    vec_cnt++;
    if (strobe_cnt !== s0 + 1 || strobe_gap !== 356 || cap_pos !== 8'd64 || cap_sample !== 9'h040) begin
      err_cnt++;
      $display("FAIL resync_frame got n=%0d gap=%0d pos=%0d sample=%h required 1/356/64/040",
               strobe_cnt - s0, strobe_gap, cap_pos, cap_sample);
    end
    drive_cycles(64, 0, 8, 256);
  endtask

  task automatic test_overlap();
    drive_cycles(64, 3, 0, 256);
    drive_cycles(64, 0, 0, 8);
    vec_cnt++;
    if (overlap_err !== 1'b1 || cap_neg !== 8'd3 || cap_sample !== 9'h03D) begin
      err_cnt++;
      $display("FAIL overlap_set got ovl=%b neg=%0d sample=%h required 1/3/03d",
               overlap_err, cap_neg, cap_sample);
    end
    drive_cycles(64, 0, 8, 256);
    drive_cycles(64, 0, 0, 8);
    vec_cnt++;
    if (overlap_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL overlap_sticky got %b required 1", overlap_err);
    end
    clear_err = 1'b1;
    drive_cycles(64, 0, 8, 9);
    clear_err = 1'b0;
    vec_cnt++;
    if (overlap_err !== 1'b0) begin
      err_cnt++;
      $display("FAIL overlap_clear got %b required 0", overlap_err);
    end
    drive_cycles(64, 0, 9, 256);
    clear_err = 1'b1;
    drive_cycles(64, 3, 0, 3);
    vec_cnt++;
    if (overlap_err !== 1'b1) begin
      err_cnt++;
      $display("FAIL overlap_beats_clear got %b required 1", overlap_err);
    end
    clear_err = 1'b0;
    drive_cycles(64, 3, 3, 256);
  endtask

  task automatic test_mid_reset();
    int s0;
    drive_cycles(64, 0, 0, 150);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if ({sample_valid, pos_level, neg_level, sample, locked, frame_err, overlap_err} !== 29'h0) begin
      err_cnt++;
      $display("FAIL mid_reset_outputs got %h required 0",
               {sample_valid, pos_level, neg_level, sample, locked, frame_err, overlap_err});
    end
    s0 = strobe_cnt;
    drive_cycles(0, 0, 150, 153);
    reset = 1'b0;
    drive_cycles(0, 0, 153, 256);
    vec_cnt++;
    if (locked !== 1'b0 || strobe_cnt !== s0) begin
      err_cnt++;
      $display("FAIL post_reset_hunt got locked=%b strobes=%0d required 0/0", locked, strobe_cnt - s0);
    end
    drive_cycles(100, 0, 0, 256);
    vec_cnt++;
    if (locked !== 1'b1 || strobe_cnt !== s0) begin
      err_cnt++;
      $display("FAIL relock got locked=%b strobes=%0d required 1/0", locked, strobe_cnt - s0);
    end
    drive_cycles(100, 0, 0, 8);
    vec_cnt++;
    if (strobe_cnt !== s0 + 1 || cap_pos !== 8'd100 || cap_neg !== 8'd0 || cap_sample !== 9'h064) begin
      err_cnt++;
      $display("FAIL relock_levels got n=%0d pos=%0d neg=%0d sample=%h required 1/100/0/064",
               strobe_cnt - s0, cap_pos, cap_neg, cap_sample);
    end
    drive_cycles(100, 0, 8, 256);
  endtask

  initial begin
    test_reset();
    test_basic_frames();
    test_levels();
    test_frame_err();
    test_overlap();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
